// File: rtl/pipe_reg_skid.sv
// Two-entry skid pipeline register: one cycle from accepted beat to out_valid, 1 beat/cycle sustained.
// in_ready is a flop (low only when both registers are full), so upstream never sees out_ready combinationally.
module pipe_reg_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= FLUSH_VAL;
      skid_q     <= FLUSH_VAL;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    // Flush wins over everything above; a beat delivered this cycle is still gone.
    if (flush) begin
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
      stall_d = '0;
    end

    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    in_ready  = in_ready_q;
    occ       = state_q;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid plus a randomized scoreboard phase.
module tb_pipe_reg_skid;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occ;
  logic [2:0]  s_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_reg_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .occ(occ), .stall_cnt(stall_cnt)
  );

  pipe_reg_skid #(.WIDTH(32), .FLUSH_VAL(32'hDEAD_BEEF), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready), .flush(flush),
    .occ(s_occ), .stall_cnt(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_d;
    logic        r0;
    logic        ir, ov;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #3;
    chk("rst_occ", occ, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_s_out_data", s_out_data, 32'hDEAD_BEEF);
    #9 rst = 1'b0;
    cyc();

    // Streaming at full rate
    in_valid = 1; in_data = 32'h11; out_ready = 1;
    cyc();
    chk("s1_valid", out_valid, 1); chk("s1_data", out_data, 32'h11); chk("s1_occ", occ, 1);
    in_data = 32'h22;
    cyc();
    chk("s2_data", out_data, 32'h22); chk("s2_occ", occ, 1);
    in_data = 32'h33;
    cyc();
    chk("s3_data", out_data, 32'h33); chk("s3_occ", occ, 1);
    in_valid = 0;
    cyc();
    chk("s4_valid", out_valid, 0); chk("s4_occ", occ, 0);

    // Backpressure into the skid register
    in_valid = 1; in_data = 32'hA1; out_ready = 0;
    cyc();
    chk("bp1_occ", occ, 1); chk("bp1_data", out_data, 32'hA1); chk("bp1_rdy", in_ready, 1);
    in_data = 32'hA2;
    cyc();
    chk("bp2_occ", occ, 2); chk("bp2_rdy", in_ready, 0); chk("bp2_data", out_data, 32'hA1);
    in_data = 32'hEE;
    cyc();
    chk("bp3_occ", occ, 2); chk("bp3_data", out_data, 32'hA1); chk("bp3_stall", stall_cnt, 2);
    in_valid = 0; out_ready = 1;
    cyc();
    chk("bp4_data", out_data, 32'hA2); chk("bp4_rdy", in_ready, 1); chk("bp4_occ", occ, 1);
    cyc();
    chk("bp5_occ", occ, 0); chk("bp5_valid", out_valid, 0);
    flush = 1;
    cyc();
    flush = 0;
    chk("bp_flush_stall", stall_cnt, 0);

    // Stall counter and saturation
    in_valid = 1; in_data = 32'h5; out_ready = 0;
    cyc();
    in_data = 32'h6;
    cyc();
    in_valid = 0;
    repeat (4) cyc();
    chk("st5_cnt", stall_cnt, 5); chk("st5_s_cnt", s_stall_cnt, 5);
    chk("st5_occ", occ, 2); chk("st5_data", out_data, 32'h5);
    repeat (5) cyc();
    chk("st10_cnt", stall_cnt, 10); chk("st10_s_sat", s_stall_cnt, 7);

    // Flush while full with a beat offered
    flush = 1; in_valid = 1; in_data = 32'hFF;
    cyc();
    flush = 0; in_valid = 0;
    chk("fl_occ", occ, 0); chk("fl_valid", out_valid, 0); chk("fl_stall", stall_cnt, 0);
    chk("fl_data", out_data, 0); chk("fl_rdy", in_ready, 1); chk("fl_s_data", s_out_data, 32'hDEAD_BEEF);
    cyc();
    chk("fl_novalid", out_valid, 0);

    // Asynchronous reset while full
    in_valid = 1; in_data = 32'hB1; out_ready = 0;
    cyc();
    in_data = 32'hB2;
    cyc();
    in_valid = 0;
    chk("ar_pre_occ", occ, 2);
    #2 rst = 1;
    #1;
    chk("ar_valid", out_valid, 0); chk("ar_rdy", in_ready, 1);
    chk("ar_data", out_data, 0); chk("ar_occ", occ, 0);
    #3 rst = 0;
    cyc();
    chk("ar_post_valid", out_valid, 0);
    in_valid = 1; in_data = 32'hC1; out_ready = 1;
    cyc();
    chk("ar_c1_data", out_data, 32'hC1); chk("ar_c1_occ", occ, 1);
    in_valid = 0;
    cyc();
    chk("ar_c1_drain", occ, 0);

    // Random traffic against a FIFO scoreboard
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      out_ready = 1'b0;
      #1 r0 = in_ready;
      out_ready = 1'b1;
      #1;
      chk("rnd_rdy_indep", in_ready, r0);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      ir = in_ready; ov = out_valid;
      if (ov && out_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 32'hXXXX_XXXX;
        chk("rnd_data", out_data, exp_d);
      end
      if (in_valid && ir) q.push_back(in_data);
      cyc();
      chk("rnd_occ", occ, q.size());
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 32'hXXXX_XXXX;
        chk("drain_data", out_data, exp_d);
      end
      cyc();
    end
    chk("drain_left", q.size(), 0);
    chk("drain_occ", occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
